fir_xifu_offload_master: RTL

- Core-side (initiator) end of the CV32E40X eXtension Interface, which the FIR coprocessor serves as responder.
- Takes offload commands from a simple valid/ready stream and drives XIF issue and commit.
- Collects XIF results and returns them on a response stream.
- Standalone driver for FIR XIFU bring-up and for integration on cores without native XIF.

---
 rtl/fir_xifu_offload_master.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fir_xifu_offload_master.sv
// Initiator side of the eXtension Interface for the FIR coprocessor: turns a command
// stream into XIF issue/commit and returns results. Optional watchdog: FIR_XIFU_OFFLOAD_TIMEOUT_EN.
module fir_xifu_offload_master #(
   parameter int X_ID_WIDTH      = 4,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [31:0]           cmd_instr_i,
   input  logic [31:0]           cmd_rs1_i,
   input  logic [31:0]           cmd_rs2_i,
   output logic                  issue_valid_o,
   input  logic                  issue_ready_i,
   output logic [31:0]           issue_instr_o,
   output logic [31:0]           issue_rs0_o,
   output logic [31:0]           issue_rs1_o,
   output logic [1:0]            issue_rs_valid_o,
   output logic [X_ID_WIDTH-1:0] issue_id_o,
   input  logic                  issue_accept_i,
   input  logic                  issue_writeback_i,
   output logic                  commit_valid_o,
   output logic [X_ID_WIDTH-1:0] commit_id_o,
   output logic                  commit_kill_o,
   input  logic                  result_valid_i,
   output logic                  result_ready_o,
   input  logic [X_ID_WIDTH-1:0] result_id_i,
   input  logic [31:0]           result_data_i,
   input  logic [4:0]            result_rd_i,
   input  logic                  result_we_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [X_ID_WIDTH-1:0] rsp_id_o,
   output logic [31:0]           rsp_data_o,
   output logic [4:0]            rsp_rd_o,
   output logic                  rsp_we_o,
   output logic                  rsp_accept_o,
   output logic                  timeout_o
);

   // state  | meaning
   // IDLE   | ready for a command while below the outstanding limit
   // ISSUE  | presenting the registered command on XIF issue
   // COMMIT | one-cycle commit of the issued ID, kill if rejected
   // REJECT | waiting for room in the response register to report a reject

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_COMMIT,
      ST_REJECT
   } state_e;

   state_e                state_q;
   logic                  run_q;
   logic [31:0]           instr_q;
   logic [31:0]           rs1_q;
   logic [31:0]           rs2_q;
   logic [X_ID_WIDTH-1:0] next_id_q;
   logic [X_ID_WIDTH-1:0] issued_id_q;
   logic                  accept_q;
   logic                  writeback_q;
   logic [OW-1:0]         outstanding_q;

   logic                  rsp_valid_q;
   logic [X_ID_WIDTH-1:0] rsp_id_q;
   logic [31:0]           rsp_data_q;
   logic [4:0]            rsp_rd_q;
   logic                  rsp_we_q;
   logic                  rsp_accept_q;

   logic cmd_hs;
   logic issue_hs;
   logic result_hs;
   logic rsp_room;
   logic reject_load;
   logic out_inc;
   logic out_dec;

   // run_q keeps every ready low while reset is asserted
   assign cmd_ready_o    = run_q && (state_q == ST_IDLE) &&
                           (outstanding_q < OW'(MAX_OUTSTANDING));
   assign cmd_hs         = cmd_valid_i && cmd_ready_o;
   assign issue_valid_o  = (state_q == ST_ISSUE);
   assign issue_hs       = issue_valid_o && issue_ready_i;
   assign rsp_room       = !rsp_valid_q || rsp_ready_i;
   assign result_ready_o = run_q && rsp_room && (state_q != ST_REJECT);
   assign result_hs      = result_valid_i && result_ready_o;
   assign reject_load    = (state_q == ST_REJECT) && rsp_room;

   assign issue_instr_o    = issue_valid_o ? instr_q : '0;
   assign issue_rs0_o      = issue_valid_o ? rs1_q : '0;
   assign issue_rs1_o      = issue_valid_o ? rs2_q : '0;
   assign issue_rs_valid_o = {2{issue_valid_o}};
   assign issue_id_o       = issue_valid_o ? next_id_q : '0;

   assign commit_valid_o = (state_q == ST_COMMIT);
   assign commit_id_o    = commit_valid_o ? issued_id_q : '0;
   assign commit_kill_o  = commit_valid_o && !accept_q;

   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_id_o     = rsp_id_q;
   assign rsp_data_o   = rsp_data_q;
   assign rsp_rd_o     = rsp_rd_q;
   assign rsp_we_o     = rsp_we_q;
   assign rsp_accept_o = rsp_accept_q;

   // writeback is captured with accept but nothing downstream consumes it yet
   logic unused_writeback;
   assign unused_writeback = writeback_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         run_q       <= 1'b0;
         instr_q     <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         next_id_q   <= '0;
         issued_id_q <= '0;
         accept_q    <= 1'b0;
         writeback_q <= 1'b0;
      end else if (clear_i) begin
         state_q     <= ST_IDLE;
         run_q       <= 1'b0;
         instr_q     <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         next_id_q   <= '0;
         issued_id_q <= '0;
         accept_q    <= 1'b0;
         writeback_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (cmd_hs) begin
                  instr_q <= cmd_instr_i;
                  rs1_q   <= cmd_rs1_i;
                  rs2_q   <= cmd_rs2_i;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (issue_ready_i) begin
                  accept_q    <= issue_accept_i;
                  writeback_q <= issue_writeback_i;
                  issued_id_q <= next_id_q;
                  next_id_q   <= next_id_q + X_ID_WIDTH'(1);
                  state_q     <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               state_q <= accept_q ? ST_IDLE : ST_REJECT;
            end
            ST_REJECT: begin
               if (rsp_room) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign out_inc = issue_hs && issue_accept_i;
   assign out_dec = result_hs && (outstanding_q != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_q <= '0;
      end else if (clear_i) begin
         outstanding_q <= '0;
      end else if (out_inc && !out_dec) begin
         outstanding_q <= outstanding_q + OW'(1);
      end else if (out_dec && !out_inc) begin
         outstanding_q <= outstanding_q - OW'(1);
      end
   end

   // Reject load and result load never coincide: result_ready_o is low in REJECT
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
         rsp_rd_q     <= '0;
         rsp_we_q     <= 1'b0;
         rsp_accept_q <= 1'b0;
      end else if (clear_i) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
         rsp_rd_q     <= '0;
         rsp_we_q     <= 1'b0;
         rsp_accept_q <= 1'b0;
      end else if (reject_load) begin
         rsp_valid_q  <= 1'b1;
         rsp_id_q     <= issued_id_q;
         rsp_data_q   <= '0;
         rsp_rd_q     <= '0;
         rsp_we_q     <= 1'b0;
         rsp_accept_q <= 1'b0;
      end else if (result_hs) begin
         rsp_valid_q  <= 1'b1;
         rsp_id_q     <= result_id_i;
         rsp_data_q   <= result_data_i;
         rsp_rd_q     <= result_rd_i;
         rsp_we_q     <= result_we_i;
         rsp_accept_q <= 1'b1;
      end else if (rsp_ready_i) begin
         rsp_valid_q  <= 1'b0;
      end
   end

`ifdef FIR_XIFU_OFFLOAD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tmr_q;
   logic          timeout_q;

   // Down-counter reloads whenever idle or a result arrives; terminal count sets the sticky flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmr_q     <= TW'(TIMEOUT_CYCLES);
         timeout_q <= 1'b0;
      end else if (clear_i) begin
         tmr_q     <= TW'(TIMEOUT_CYCLES);
         timeout_q <= 1'b0;
      end else if ((outstanding_q == '0) || result_hs) begin
         tmr_q <= TW'(TIMEOUT_CYCLES);
      end else if (tmr_q != '0) begin
         tmr_q <= tmr_q - TW'(1);
         if (tmr_q == TW'(1)) timeout_q <= 1'b1;
      end
   end

   assign timeout_o = timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timeout_o = 1'b0;
`endif

endmodule
